// File: rtl/cpu_seq_ctrl_pkg.sv
// cpu_seq_ctrl_pkg: sequencer state encoding and parameter defaults
package cpu_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_MULDIV = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam int unsigned RST_WAIT_DEF = 2;
   localparam int unsigned TMO_W_DEF    = 8;

endpackage

// File: rtl/cpu_seq_ctrl_watchdog.sv
// cpu_seq_ctrl_watchdog: per-state wait counter that flags a stuck handshake
module cpu_seq_ctrl_watchdog
   import cpu_seq_ctrl_pkg::*;
#(
   parameter int unsigned TMO_W = TMO_W_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   // Expires on the cycle that would take the count to all-ones, i.e. the
   // (2**TMO_W-1)th consecutive waiting cycle in one state.
   localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   logic [TMO_W-1:0] cnt_q;

   // count waiting cycles, restarting on every state change
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   cnt_q <= '0;
      else if (i_clr) cnt_q <= '0;
      else if (i_en)  cnt_q <= cnt_q + 1'b1;
   end

   assign o_expired = i_en && (cnt_q == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/exec/mem/muldiv sequencer with retire gating
module cpu_seq_ctrl
   import cpu_seq_ctrl_pkg::*;
#(
   parameter int unsigned RST_WAIT     = RST_WAIT_DEF,
   parameter int unsigned TMO_W        = TMO_W_DEF,
   parameter logic [31:0] INSTRET_INIT = 32'h0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_imem_stall,
   input  logic        i_dmem_stall,
   input  logic        i_is_load,
   input  logic        i_is_store,
   input  logic        i_muldiv,
   input  logic        i_muldiv_done,
   input  logic        i_ecall,
   output logic        o_pc_stall,
   output logic        o_imem_cen,
   output logic        o_dmem_cen,
   output logic        o_dmem_wen,
   output logic        o_muldiv_start,
   output logic        o_rf_wen_gate,
   output logic [31:0] o_instret,
   output logic        o_finish,
   output logic        o_error
);

   localparam int unsigned BW = $clog2(RST_WAIT + 1);

   state_t        state_q, state_nxt;
   logic [BW-1:0] boot_q;
   logic [31:0]   instret_q;
   logic          boot_done, mem_op, retire, wd_en, wd_exp;

   assign boot_done = boot_q == BW'(RST_WAIT - 1);
   assign mem_op    = i_is_load || i_is_store;
   assign wd_en     = state_q == S_FETCH || state_q == S_MEM || state_q == S_MULDIV;

   cpu_seq_ctrl_watchdog #(.TMO_W(TMO_W)) u_wd (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (state_nxt != state_q),
      .i_en     (wd_en),
      .o_expired(wd_exp)
   );

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_BOOT;
      else          state_q <= state_nxt;
   end

   // post-reset settle counter, only advances in S_BOOT
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                             boot_q <= '0;
      else if (state_q == S_BOOT && !boot_done) boot_q <= boot_q + 1'b1;
   end

   // retired-instruction counter, wraps naturally
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) instret_q <= INSTRET_INIT;
      else          instret_q <= instret_q + 32'(retire);
   end

   // next state and Mealy outputs; a watchdog expiry overrides any handshake
   always_comb begin
      state_nxt      = state_q;
      retire         = 1'b0;
      o_dmem_cen     = 1'b0;
      o_muldiv_start = 1'b0;
      case (state_q)
         S_BOOT:   state_nxt = boot_done ? S_FETCH : S_BOOT;
         S_FETCH:  state_nxt = wd_exp ? S_ERR : (i_imem_stall ? S_FETCH : S_EXEC);
         S_EXEC: begin
            state_nxt      = i_ecall ? S_HALT : mem_op ? S_MEM : i_muldiv ? S_MULDIV : S_FETCH;
            o_dmem_cen     = !i_ecall && mem_op;
            o_muldiv_start = !i_ecall && !mem_op && i_muldiv;
            retire         = !i_ecall && !mem_op && !i_muldiv;
         end
         S_MEM: begin
            state_nxt = wd_exp ? S_ERR : (i_dmem_stall ? S_MEM : S_FETCH);
            retire    = !wd_exp && !i_dmem_stall;
         end
         S_MULDIV: begin
            state_nxt = wd_exp ? S_ERR : (i_muldiv_done ? S_FETCH : S_MULDIV);
            retire    = !wd_exp && i_muldiv_done;
         end
         default:  state_nxt = state_q;
      endcase
   end

   assign o_pc_stall    = !retire;
   assign o_rf_wen_gate = retire;
   assign o_imem_cen    = state_q == S_FETCH;
   assign o_dmem_wen    = o_dmem_cen && i_is_store;
   assign o_instret     = instret_q;
   assign o_finish      = state_q == S_HALT;
   assign o_error       = state_q == S_ERR;

endmodule
